// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage between ExecuteCalc and MemWB.
//
// The stage takes one instruction from execute. For a legal load or store it
// issues a single data-memory request over a req/ack handshake. It also
// builds the byte enables and the lane-replicated store data. For loads it
// shifts the returned word so the addressed byte sits at bit 0; MemWB does
// the sign/zero extension. Upstream is stalled while a request is
// outstanding. A misaligned or illegal-width access does not touch memory.
// It becomes a no-writeback bubble (wb_wb_op = WNONE) plus a one-cycle
// exception pulse.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ex_valid          execute-stage instruction valid
//   ex_mem_op         0=NONE 1=LOAD 2=STORE 3=reserved (as NONE)
//   ex_wb_op          writeback selector, passed through
//   ex_funct3         access width/sign (0=B 1=H 2=W 4=BU 5=HU)
//   ex_alu_result     ALU result / byte address
//   ex_rs2_data       store data
//   ex_rd, ex_pc      destination register id, instruction PC
//   stall_out         upstream must hold ex_* this cycle
//   mem_req/we/addr/wdata/be   data-memory request (held until mem_ack)
//   mem_ack, mem_rdata         memory completion and load word
//   wb_*              registered outputs to MemWB
//   wb_mem_data       load word shifted right by addr[1:0]*8
//   misalign_exc      one-cycle fault pulse, aligned with its wb bubble
//   misalign_addr     last faulting byte address
// ----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [1:0]        ex_mem_op,
    input  logic [2:0]        ex_wb_op,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_rs2_data,
    input  logic [7:0]        ex_rd,
    input  logic [31:0]       ex_pc,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_wb_op,
    output logic [2:0]        wb_funct3,
    output logic [31:0]       wb_alu_result,
    output logic [7:0]        wb_rd,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_mem_data,
    output logic              misalign_exc,
    output logic [31:0]       misalign_addr
);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [2:0] WB_NONE  = 3'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------------
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'd0:    be = 4'b0001 << a;
            2'd1:    be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic access_bad(input logic [2:0] f3, input logic store,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
        if (store && f3[2])                         bad = 1'b1;
        if (f3[1:0] == 2'd1 && a[0])                bad = 1'b1;
        if (f3 == 3'd2 && a != 2'd0)                bad = 1'b1;
        return bad;
    endfunction

    // ------------------------------------------------------------------------
    // Stage p0: combinational decode of the execute-stage instruction
    // ------------------------------------------------------------------------
    logic              is_mem_p0;
    logic              is_store_p0;
    logic              bad_p0;
    logic              go_mem_p0;
    logic              ack_p0;
    logic [ADDR_W-1:0] addr_word_p0;

    assign is_mem_p0    = (ex_mem_op == OP_LOAD) || (ex_mem_op == OP_STORE);
    assign is_store_p0  = (ex_mem_op == OP_STORE);
    assign bad_p0       = is_mem_p0 && access_bad(ex_funct3, is_store_p0, ex_alu_result[1:0]);
    assign go_mem_p0    = ex_valid && is_mem_p0 && !bad_p0;
    // An ack is only meaningful while a request is actually outstanding.
    assign ack_p0       = mem_ack && mem_req;
    assign addr_word_p0 = ADDR_W'(ex_alu_result) & ~ADDR_W'(3);

    assign stall_out = (state == WAIT) && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_mem_p0) state_nxt = WAIT;
            WAIT:    if (ack_p0)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage p1: instruction captured while its memory access is in flight
    // ------------------------------------------------------------------------
    logic [2:0]  wb_op_p1;
    logic [2:0]  funct3_p1;
    logic [31:0] alu_p1;
    logic [7:0]  rd_p1;
    logic [31:0] pc_p1;
    logic        load_p1;
    logic [1:0]  lane_p1;

    always_ff @(posedge clk) begin
        if (state == IDLE && go_mem_p0) begin
            wb_op_p1  <= ex_wb_op;
            funct3_p1 <= ex_funct3;
            alu_p1    <= ex_alu_result;
            rd_p1     <= ex_rd;
            pc_p1     <= ex_pc;
            load_p1   <= !is_store_p0;
            lane_p1   <= ex_alu_result[1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Stage p2: registered memory request and MemWB outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            wb_valid      <= 1'b0;
            wb_wb_op      <= WB_NONE;
            wb_funct3     <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
            wb_pc         <= '0;
            wb_mem_data   <= '0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (go_mem_p0) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store_p0;
                            mem_addr  <= addr_word_p0;
                            mem_be    <= be_gen(ex_funct3, ex_alu_result[1:0]);
                            mem_wdata <= wdata_gen(ex_funct3, ex_rs2_data);
                        end else begin
                            // Pass-through op, or a faulting access turned into a bubble.
                            wb_valid      <= 1'b1;
                            wb_wb_op      <= bad_p0 ? WB_NONE : ex_wb_op;
                            wb_funct3     <= ex_funct3;
                            wb_alu_result <= ex_alu_result;
                            wb_rd         <= ex_rd;
                            wb_pc         <= ex_pc;
                            wb_mem_data   <= '0;
                            if (bad_p0) begin
                                misalign_exc  <= 1'b1;
                                misalign_addr <= ex_alu_result;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (ack_p0) begin
                        mem_req       <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_wb_op      <= wb_op_p1;
                        wb_funct3     <= funct3_p1;
                        wb_alu_result <= alu_p1;
                        wb_rd         <= rd_p1;
                        wb_pc         <= pc_p1;
                        wb_mem_data   <= load_p1 ? (mem_rdata >> {lane_p1, 3'b000}) : 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage. Stimulus pushes the expected MemWB
// record into a scoreboard queue. A monitor on the falling edge pops and
// compares every wb_valid beat. Request-side outputs are checked directly
// by the stimulus one time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [1:0]  ex_mem_op;
    logic [2:0]  ex_wb_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [7:0]  ex_rd;
    logic [31:0] ex_pc;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_wb_op;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_alu_result;
    logic [7:0]  wb_rd;
    logic [31:0] wb_pc;
    logic [31:0] wb_mem_data;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_wb_op(ex_wb_op),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wb_op(wb_wb_op), .wb_funct3(wb_funct3),
        .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .wb_pc(wb_pc),
        .wb_mem_data(wb_mem_data), .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  wb_op;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [7:0]  rd;
        logic [31:0] pc;
        logic [31:0] mdata;
        logic        exc;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] mop, input logic [2:0] wop,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [7:0] rd,
                         input logic [31:0] pc);
        ex_valid = v; ex_mem_op = mop; ex_wb_op = wop; ex_funct3 = f3;
        ex_alu_result = alu; ex_rs2_data = rs2; ex_rd = rd; ex_pc = pc;
    endtask

    task automatic expect_wb(input logic [2:0] wop, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [7:0] rd,
                             input logic [31:0] pc, input logic [31:0] md,
                             input logic exc);
        wb_exp_t e;
        e = '{wb_op: wop, funct3: f3, alu: alu, rd: rd, pc: pc, mdata: md, exc: exc};
        exp_q.push_back(e);
    endtask

    // Monitor: every wb_valid beat must match the oldest expected record.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got wb_valid=1 pc=0x%08h expected no beat at %0t",
                         wb_pc, $time);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_pc",         wb_pc,                  e.pc);
                chk("wb_wb_op",      {29'd0, wb_wb_op},      {29'd0, e.wb_op});
                chk("wb_funct3",     {29'd0, wb_funct3},     {29'd0, e.funct3});
                chk("wb_alu_result", wb_alu_result,          e.alu);
                chk("wb_rd",         {24'd0, wb_rd},         {24'd0, e.rd});
                chk("wb_mem_data",   wb_mem_data,            e.mdata);
                chk("misalign_exc",  {31'd0, misalign_exc},  {31'd0, e.exc});
                if (e.exc) chk("misalign_addr", misalign_addr, e.alu);
            end
        end else if (misalign_exc) begin
            total++;
            bad++;
            $display("FAIL exc_without_wb: got misalign_exc=1 expected 0 at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        tick();
        tick();
        chk("rst_mem_req",  {31'd0, mem_req},      32'd0);
        chk("rst_mem_be",   {28'd0, mem_be},       32'd0);
        chk("rst_mem_addr", mem_addr,              32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid},     32'd0);
        chk("rst_wb_op",    {29'd0, wb_wb_op},     32'd0);
        chk("rst_stall",    {31'd0, stall_out},    32'd0);
        chk("rst_exc_addr", misalign_addr,         32'd0);
        reset = 1'b0;
        tick();

        // ALU pass-through
        drive(1'b1, 2'd0, 3'd3, 3'd0, 32'h1234, 32'd0, 8'd5, 32'h100);
        expect_wb(3'd3, 3'd0, 32'h1234, 8'd5, 32'h100, 32'd0, 1'b0);
        chk("alu_stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("alu_mem_req", {31'd0, mem_req}, 32'd0);
        chk("alu_stall2",  {31'd0, stall_out}, 32'd0);
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        tick();

        // SB with ack three cycles late
        drive(1'b1, 2'd2, 3'd0, 3'd0, 32'h1003, 32'hAABBCCDD, 8'd0, 32'h104);
        expect_wb(3'd0, 3'd0, 32'h1003, 8'd0, 32'h104, 32'd0, 1'b0);
        tick();
        chk("sb_req",   {31'd0, mem_req}, 32'd1);
        chk("sb_we",    {31'd0, mem_we},  32'd1);
        chk("sb_addr",  mem_addr,         32'h1000);
        chk("sb_be",    {28'd0, mem_be},  32'h8);
        chk("sb_wdata", mem_wdata,        32'hDDDDDDDD);
        chk("sb_stall", {31'd0, stall_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sb_hold_stall", {31'd0, stall_out}, 32'd1);
            chk("sb_hold_req",   {31'd0, mem_req},   32'd1);
            chk("sb_hold_addr",  mem_addr,           32'h1000);
            chk("sb_hold_wdata", mem_wdata,          32'hDDDDDDDD);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        chk("sb_done_req",   {31'd0, mem_req},   32'd0);
        chk("sb_done_stall", {31'd0, stall_out}, 32'd0);
        chk("sb_done_wbv",   {31'd0, wb_valid},  32'd1);
        tick();

        // LHU, ack in the first WAIT cycle
        drive(1'b1, 2'd1, 3'd4, 3'd5, 32'h2002, 32'd0, 8'd7, 32'h108);
        expect_wb(3'd4, 3'd5, 32'h2002, 8'd7, 32'h108, 32'h000080FF, 1'b0);
        tick();
        chk("lhu_req",  {31'd0, mem_req}, 32'd1);
        chk("lhu_we",   {31'd0, mem_we},  32'd0);
        chk("lhu_be",   {28'd0, mem_be},  32'hC);
        chk("lhu_addr", mem_addr,         32'h2000);
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h80FF1234;
        tick();
        mem_ack = 1'b0;
        chk("lhu_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lhu_req_off", {31'd0, mem_req}, 32'd0);
        tick();

        // Misaligned LW
        drive(1'b1, 2'd1, 3'd4, 3'd2, 32'h3001, 32'd0, 8'd9, 32'h10C);
        expect_wb(3'd0, 3'd2, 32'h3001, 8'd9, 32'h10C, 32'd0, 1'b1);
        chk("mis_stall", {31'd0, stall_out}, 32'd0);
        tick();
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        chk("mis_req",  {31'd0, mem_req},      32'd0);
        chk("mis_exc",  {31'd0, misalign_exc}, 32'd1);
        chk("mis_addr", misalign_addr,         32'h3001);
        tick();
        chk("mis_exc_clr",   {31'd0, misalign_exc}, 32'd0);
        chk("mis_addr_hold", misalign_addr,         32'h3001);

        // SH at offset 2: upper half lanes, replicated halfword
        drive(1'b1, 2'd2, 3'd0, 3'd1, 32'h5002, 32'h1234ABCD, 8'd0, 32'h118);
        expect_wb(3'd0, 3'd1, 32'h5002, 8'd0, 32'h118, 32'd0, 1'b0);
        tick();
        chk("sh_be",    {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata,       32'hABCDABCD);
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        // Store with an unsigned width is illegal
        drive(1'b1, 2'd2, 3'd0, 3'd4, 32'h5100, 32'd0, 8'd0, 32'h11C);
        expect_wb(3'd0, 3'd4, 32'h5100, 8'd0, 32'h11C, 32'd0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        chk("sbu_req",  {31'd0, mem_req}, 32'd0);
        chk("sbu_addr", misalign_addr,    32'h5100);
        tick();

        // Load then ALU op held under stall
        drive(1'b1, 2'd1, 3'd4, 3'd2, 32'h4000, 32'd0, 8'd3, 32'h110);
        expect_wb(3'd4, 3'd2, 32'h4000, 8'd3, 32'h110, 32'h11223344, 1'b0);
        tick();
        drive(1'b1, 2'd0, 3'd3, 3'd0, 32'h55, 32'd0, 8'd4, 32'h114);
        expect_wb(3'd3, 3'd0, 32'h55, 8'd4, 32'h114, 32'd0, 1'b0);
        chk("b2b_stall1", {31'd0, stall_out}, 32'd1);
        tick();
        chk("b2b_stall2", {31'd0, stall_out}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h11223344;
        tick();
        mem_ack = 1'b0;
        chk("b2b_accept_stall", {31'd0, stall_out}, 32'd0);
        tick();
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        chk("b2b_alu_wbv", {31'd0, wb_valid}, 32'd1);
        tick();

        // Reset while a request is outstanding
        drive(1'b1, 2'd1, 3'd4, 3'd0, 32'h6001, 32'd0, 8'd6, 32'h120);
        tick();
        chk("rw_req", {31'd0, mem_req}, 32'd1);
        chk("rw_be",  {28'd0, mem_be},  32'h2);
        drive(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 32'd0, 8'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("rw_stall_in_reset", {31'd0, stall_out}, 32'd0);
        tick();
        reset = 1'b0;
        chk("rw_req_off", {31'd0, mem_req},   32'd0);
        chk("rw_stall",   {31'd0, stall_out}, 32'd0);
        chk("rw_wbv",     {31'd0, wb_valid},  32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rw_late_ack_wbv", {31'd0, wb_valid}, 32'd0);
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage between ExecuteCalc and MemWB in the CPU example.
- Takes the executed instruction and issues data-memory load/store requests over a req/ack handshake.
- Generates byte enables and replicated store data, and aligns load data to bit 0 before handing it to MemWB, which does the sign/zero extension.
- Stalls upstream while a memory access is outstanding. Detects misaligned or illegal-width accesses and turns them into a no-writeback bubble plus an exception pulse.

Parameters:
- ADDR_W, 32, data-memory address width; must be >= 3.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  instruction from execute is valid
- ex_mem_op  input  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- ex_wb_op  input  3  Wb enum (WNONE, PC2, PC4, ALU, MEM), passed through
- ex_funct3  input  3  access width/sign (0=B, 1=H, 2=W, 4=BU, 5=HU)
- ex_alu_result  input  32  ALU result; byte address for mem ops
- ex_rs2_data  input  32  store data
- ex_rd  input  8  destination register id
- ex_pc  input  32  instruction PC
- stall_out  output  1  upstream must hold ex_* stable this cycle
- mem_req  output  1  memory request valid
- mem_we  output  1  1=store, 0=load
- mem_addr  output  ADDR_W  word-aligned address (low 2 bits zero)
- mem_wdata  output  32  store data, lane-replicated
- mem_be  output  4  byte enables
- mem_ack  input  1  memory accepted/completed the request; mem_rdata valid
- mem_rdata  input  32  load data, full word
- wb_valid, wb_wb_op(3), wb_funct3(3), wb_alu_result(32), wb_rd(8), wb_pc(32)  output  registered stage outputs to MemWB
- wb_mem_data  output  32  load word shifted right by addr[1:0]*8
- misalign_exc  output  1  one-cycle pulse, aligned with the wb_valid bubble it accompanies
- misalign_addr  output  32  faulting byte address, held until the next fault

Behaviour:
- Reset values:
  - FSM in IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - wb_valid=0, all wb_* fields=0 (wb_wb_op=WNONE), misalign_exc=0, misalign_addr=0.
- FSM states are IDLE and WAIT.
- stall_out = (state==WAIT), combinational; it is 0 in IDLE and during reset.
- Accept rule: the stage accepts ex_* in any IDLE cycle with ex_valid=1.
- Pass-through (mem_op NONE/3): wb_* = ex_* on the next edge, wb_valid=1, wb_mem_data=0. Latency 1, no stall.
- Legal mem op, on accept:
  - Capture the instruction and set mem_req=1 and the mem_* fields on the next edge; go to WAIT.
  - wb_valid=0 that edge.
- WAIT:
  - mem_req and all mem_* fields are held constant until a cycle with mem_ack=1.
  - On that ack edge: mem_req=0, state=IDLE, wb_valid=1, wb_* = captured fields.
  - For loads, wb_mem_data = mem_rdata >> (addr[1:0]*8). For stores, wb_mem_data=0.
  - Minimum mem-op latency is 2 cycles (ack in the first WAIT cycle). The next instruction can be accepted in the cycle after ack.
- mem_ack is ignored when mem_req=0.
- Byte enables and store data (a = addr[1:0]):
  - B/BU: be = 4'b0001 << a, wdata = {4{rs2[7:0]}}.
  - H/HU: be = 4'b0011 << a, wdata = {2{rs2[15:0]}}.
  - W: be = 4'hF, wdata = rs2.
  - Loads drive the same be pattern.
- Illegal/misaligned cases, for a mem op only:
  - funct3 is 3, 6 or 7;
  - a store with funct3 4 or 5;
  - H with a[0]=1;
  - W with a!=0.
- Required response to an illegal/misaligned access:
  - No memory request is issued and there is no stall.
  - Next edge: wb_valid=1 with wb_wb_op forced to WNONE, misalign_exc=1 for exactly one cycle, misalign_addr=ex_alu_result.
- Instructions with ex_valid=0 produce wb_valid=0 on the next edge.
- Reset during WAIT: next edge gives IDLE, mem_req=0, wb_valid=0. A late ack after reset is ignored.
- Address arithmetic: mem_addr = {alu_result[ADDR_W-1:2], 2'b00}; bits above ADDR_W are dropped with no wrap check.

Test Plan:
- ALU op: ex_valid=1, mem_op=NONE, wb_op=ALU, alu=0x1234, rd=5 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5; stall_out stays 0, mem_req stays 0.
- SB: alu=0x1003, rs2=0xAABBCCDD, funct3=0 -> mem_req=1, mem_we=1, mem_addr=0x1000, mem_be=0x8, mem_wdata=0xDDDDDDDD. Ack delayed 3 cycles -> stall_out=1 for 4 cycles and outputs stable; wb_valid=1 one cycle after ack.
- LHU: alu=0x2002, funct3=5, mem_rdata=0x80FF1234, ack in first WAIT cycle -> mem_be=0xC, wb_mem_data=0x000080FF, total latency 2 cycles.
- Misaligned LW: alu=0x3001, funct3=2 -> no mem_req; next cycle wb_valid=1, wb_wb_op=WNONE, misalign_exc=1 for 1 cycle, misalign_addr=0x3001.
- Back-to-back load then ALU op held under stall -> the ALU op is accepted the cycle after ack; wb_valid pulses are in order and the load's wb_pc precedes the ALU op's.
- Reset asserted while in WAIT with mem_req=1 -> next cycle mem_req=0, stall_out=0, wb_valid=0; an ack 1 cycle later produces no wb_valid.
